// File: rtl/ysyx_220066_mem_arb.sv
// Arbitrates a fetch port and a load/store port onto one memory port: alternating
// priority on contention, one outstanding transaction, and a per-transaction timeout.
module ysyx_220066_mem_arb #(
  parameter logic [7:0] TIMEOUT = 8'd255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_valid,
  input  logic [63:0] if_addr,
  output logic        if_ready,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  output logic        if_err,
  input  logic        ls_valid,
  input  logic        ls_we,
  input  logic [2:0]  ls_op,
  input  logic [63:0] ls_addr,
  input  logic [63:0] ls_wdata,
  output logic        ls_ready,
  output logic        ls_rvalid,
  output logic [63:0] ls_rdata,
  output logic        ls_err,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic        mem_we,
  output logic [2:0]  mem_op,
  output logic [63:0] mem_addr,
  output logic [63:0] mem_wdata,
  input  logic        mem_rvalid,
  input  logic [63:0] mem_rdata,
  input  logic        mem_err
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    REQ_IF  = 3'd1,
    REQ_LS  = 3'd2,
    WAIT_IF = 3'd3,
    WAIT_LS = 3'd4
  } state_t;

  state_t      state_r, state_s;
  logic        last_ls_r;
  logic [7:0]  cnt_r;
  logic        grant_if_s, grant_ls_s, done_if_s, done_ls_s, tmo_s, expired_s;
  logic        if_rvalid_r, ls_rvalid_r, if_err_r, ls_err_r, mem_we_r;
  logic [31:0] if_rdata_r;
  logic [63:0] ls_rdata_r, mem_addr_r, mem_wdata_r;
  logic [2:0]  mem_op_r;

  assign expired_s = (cnt_r == TIMEOUT);

  // Next-state, grant decision and transaction completion (normal or timed out)
  always_comb begin
    state_s    = state_r;
    grant_if_s = 1'b0;
    grant_ls_s = 1'b0;
    done_if_s  = 1'b0;
    done_ls_s  = 1'b0;
    tmo_s      = 1'b0;
    case (state_r)
      IDLE: begin
        // No grant while a response pulse is on the outputs.
        if (!if_rvalid_r && !ls_rvalid_r) begin
          if (if_valid && ls_valid) begin
            grant_if_s = last_ls_r;
            grant_ls_s = !last_ls_r;
          end else begin
            grant_if_s = if_valid;
            grant_ls_s = ls_valid;
          end
        end else begin
          grant_if_s = 1'b0;
          grant_ls_s = 1'b0;
        end
        if (grant_if_s) state_s = REQ_IF;
        else if (grant_ls_s) state_s = REQ_LS;
        else state_s = IDLE;
      end
      REQ_IF, REQ_LS: begin
        if (expired_s) begin
          tmo_s     = 1'b1;
          done_if_s = (state_r == REQ_IF);
          done_ls_s = (state_r == REQ_LS);
          state_s   = IDLE;
        end else if (mem_ready) begin
          state_s = (state_r == REQ_IF) ? WAIT_IF : WAIT_LS;
        end else begin
          state_s = state_r;
        end
      end
      WAIT_IF, WAIT_LS: begin
        // A response landing on the expiry cycle still counts as a normal response.
        if (mem_rvalid) begin
          done_if_s = (state_r == WAIT_IF);
          done_ls_s = (state_r == WAIT_LS);
          state_s   = IDLE;
        end else if (expired_s) begin
          tmo_s     = 1'b1;
          done_if_s = (state_r == WAIT_IF);
          done_ls_s = (state_r == WAIT_LS);
          state_s   = IDLE;
        end else begin
          state_s = state_r;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_r <= IDLE;
    else      state_r <= state_s;
  end

  // Request latch, last-grant memory and timeout counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_addr_r  <= 64'd0;
      mem_wdata_r <= 64'd0;
      mem_we_r    <= 1'b0;
      mem_op_r    <= 3'd0;
      last_ls_r   <= 1'b0;
      cnt_r       <= 8'd0;
    end else if (grant_if_s) begin
      mem_addr_r  <= if_addr;
      mem_wdata_r <= 64'd0;
      mem_we_r    <= 1'b0;
      mem_op_r    <= 3'b011;
      last_ls_r   <= 1'b0;
      cnt_r       <= 8'd0;
    end else if (grant_ls_s) begin
      mem_addr_r  <= ls_addr;
      mem_wdata_r <= ls_wdata;
      mem_we_r    <= ls_we;
      mem_op_r    <= ls_op;
      last_ls_r   <= 1'b1;
      cnt_r       <= 8'd0;
    end else if (state_r != IDLE) begin
      cnt_r <= cnt_r + 8'd1;
    end
  end

  // Response capture: rvalid pulses one cycle after completion with registered data
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      if_rvalid_r <= 1'b0;
      ls_rvalid_r <= 1'b0;
      if_err_r    <= 1'b0;
      ls_err_r    <= 1'b0;
      if_rdata_r  <= 32'd0;
      ls_rdata_r  <= 64'd0;
    end else begin
      if_rvalid_r <= done_if_s;
      ls_rvalid_r <= done_ls_s;
      if (done_if_s) begin
        if_err_r   <= tmo_s | mem_err;
        if_rdata_r <= tmo_s ? 32'd0 : (mem_addr_r[2] ? mem_rdata[63:32] : mem_rdata[31:0]);
      end
      if (done_ls_s) begin
        ls_err_r   <= tmo_s | mem_err;
        ls_rdata_r <= tmo_s ? 64'd0 : mem_rdata;
      end
    end
  end

  // Ready is combinational so the winner sees it in the grant cycle; reset masks it.
  assign if_ready  = grant_if_s & rst;
  assign ls_ready  = grant_ls_s & rst;
  assign mem_valid = (state_r == REQ_IF) || (state_r == REQ_LS);
  assign mem_we    = mem_we_r;
  assign mem_op    = mem_op_r;
  assign mem_addr  = mem_addr_r;
  assign mem_wdata = mem_wdata_r;
  assign if_rvalid = if_rvalid_r;
  assign if_rdata  = if_rdata_r;
  assign if_err    = if_err_r;
  assign ls_rvalid = ls_rvalid_r;
  assign ls_rdata  = ls_rdata_r;
  assign ls_err    = ls_err_r;

endmodule

// File: tb/tb_ysyx_220066_mem_arb.sv
// Directed and randomized bench for ysyx_220066_mem_arb against a transaction-level model.
module tb_ysyx_220066_mem_arb;
  localparam logic [7:0] TMO = 8'd8;

  logic        clk, rst;
  logic        if_valid, if_ready, if_rvalid, if_err;
  logic [63:0] if_addr;
  logic [31:0] if_rdata;
  logic        ls_valid, ls_we, ls_ready, ls_rvalid, ls_err;
  logic [2:0]  ls_op;
  logic [63:0] ls_addr, ls_wdata, ls_rdata;
  logic        mem_valid, mem_ready, mem_we, mem_rvalid, mem_err;
  logic [2:0]  mem_op;
  logic [63:0] mem_addr, mem_wdata, mem_rdata;

  int checks = 0;
  int failures = 0;
  int pulses;

  // Model state and the next transaction's requester fields
  logic        mdl_last_ls;
  logic        exp_is_if, exp_we;
  logic [2:0]  exp_op;
  logic [63:0] exp_addr, exp_wdata;
  logic [63:0] t_if_addr, t_ls_addr, t_wdata;
  logic        t_we;
  logic [2:0]  t_op;
  logic        outs_or;

  assign outs_or = |{mem_valid, mem_we, mem_op, mem_addr, mem_wdata, if_ready, if_rvalid,
                     if_err, if_rdata, ls_ready, ls_rvalid, ls_err, ls_rdata};

  ysyx_220066_mem_arb #(.TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .if_valid(if_valid), .if_addr(if_addr), .if_ready(if_ready), .if_rvalid(if_rvalid),
    .if_rdata(if_rdata), .if_err(if_err),
    .ls_valid(ls_valid), .ls_we(ls_we), .ls_op(ls_op), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
    .ls_ready(ls_ready), .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata), .ls_err(ls_err),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_we(mem_we), .mem_op(mem_op),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata), .mem_err(mem_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Memory side: hold off acceptance rd cycles, respond rsp cycles after acceptance.
  task automatic serve(input int rd, input int rsp, input logic [63:0] rdat, input logic err);
    for (int i = 0; i <= rd; i++) begin
      mem_ready  = (i == rd);
      mem_rvalid = (i < rd) ? 1'($urandom_range(1, 0)) : 1'b0;
      mem_rdata  = {$urandom, $urandom};
      mem_err    = 1'b1;
      #1;
      chk("req_mem_valid", mem_valid, 1'b1);
      chk("req_mem_addr", mem_addr, exp_addr);
      chk("req_mem_we", mem_we, exp_we);
      chk("req_mem_op", mem_op, exp_op);
      if (!exp_is_if) chk("req_mem_wdata", mem_wdata, exp_wdata);
      chk("busy_ready", {if_ready, ls_ready}, 2'b00);
      cyc();
    end
    mem_ready = 1'b0; mem_rvalid = 1'b0; mem_err = 1'b0;
    for (int i = 0; i < rsp; i++) begin
      #1;
      chk("wait_mem_valid", mem_valid, 1'b0);
      chk("wait_no_rvalid", {if_rvalid, ls_rvalid}, 2'b00);
      cyc();
    end
    mem_rvalid = 1'b1; mem_rdata = rdat; mem_err = err;
    cyc();
    mem_rvalid = 1'b0; mem_rdata = 64'd0; mem_err = 1'b0;
  endtask

  // One complete transaction: grant per arbitration rules, memory handshake, response.
  task automatic do_txn(input logic iv, input logic lv, input logic keep, input int rd,
                        input int rsp, input logic [63:0] rdat, input logic err);
    logic        win_ls;
    logic [63:0] exp_r;
    win_ls      = (iv && lv) ? !mdl_last_ls : lv;
    mdl_last_ls = win_ls;
    exp_is_if   = !win_ls;
    exp_addr    = win_ls ? t_ls_addr : t_if_addr;
    exp_we      = win_ls ? t_we : 1'b0;
    exp_op      = win_ls ? t_op : 3'b011;
    exp_wdata   = t_wdata;
    if_valid = iv; if_addr = t_if_addr;
    ls_valid = lv; ls_addr = t_ls_addr; ls_we = t_we; ls_op = t_op; ls_wdata = t_wdata;
    #1;
    chk("grant_if_ready", if_ready, !win_ls);
    chk("grant_ls_ready", ls_ready, win_ls);
    cyc();
    if (!keep) begin
      if_valid = 1'b0; ls_valid = 1'b0;
    end
    serve(rd, rsp, rdat, err);
    exp_r = exp_is_if ? ((rdat >> (exp_addr[2] ? 32 : 0)) & 64'h0000_0000_FFFF_FFFF) : rdat;
    #1;
    chk("resp_if_rvalid", if_rvalid, exp_is_if);
    chk("resp_ls_rvalid", ls_rvalid, !exp_is_if);
    if (exp_is_if) begin
      chk("resp_if_rdata", if_rdata, exp_r);
      chk("resp_if_err", if_err, err);
    end else begin
      chk("resp_ls_rdata", ls_rdata, exp_r);
      chk("resp_ls_err", ls_err, err);
    end
    chk("no_grant_on_pulse", {if_ready, ls_ready}, 2'b00);
    cyc();
    chk("pulse_one_cycle", {if_rvalid, ls_rvalid}, 2'b00);
  endtask

  initial begin
    rst = 1'b1; if_valid = 1'b0; if_addr = 64'd0;
    ls_valid = 1'b0; ls_we = 1'b0; ls_op = 3'd0; ls_addr = 64'd0; ls_wdata = 64'd0;
    mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = 64'd0; mem_err = 1'b0;
    mdl_last_ls = 1'b0;
    #2 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs", outs_or, 1'b0);
    rst = 1'b1;
    cyc();

    // Contention right after reset: LS, then IF, then LS again
    t_if_addr = 64'h8000_0000; t_ls_addr = 64'h8000_2008; t_we = 1'b0; t_op = 3'b100;
    t_wdata = 64'd0;
    do_txn(1'b1, 1'b1, 1'b1, 0, 0, 64'hAAAA_BBBB_CCCC_DDDD, 1'b0);
    do_txn(1'b1, 1'b1, 1'b1, 1, 1, 64'h5555_6666_7777_8888, 1'b0);
    do_txn(1'b1, 1'b1, 1'b0, 0, 2, 64'h9999_0000_1234_5678, 1'b0);

    // Lone fetch from an odd word: upper half selected
    t_if_addr = 64'h8000_0004;
    do_txn(1'b1, 1'b0, 1'b0, 0, 1, 64'h1111_2222_3333_4444, 1'b0);
    chk("lone_fetch_rdata_const", if_rdata, 32'h1111_2222);

    // Store held off by mem_ready=0 for 5 cycles
    t_ls_addr = 64'h8000_1000; t_we = 1'b1; t_op = 3'b011; t_wdata = 64'h0000_0000_DEAD_BEEF;
    do_txn(1'b0, 1'b1, 1'b0, 5, 1, 64'h0, 1'b0);

    // Bus error on a fetch
    t_if_addr = 64'h8000_0010;
    do_txn(1'b1, 1'b0, 1'b0, 0, 0, 64'hCAFE_F00D_1234_5678, 1'b1);

    // Responses arriving exactly on the expiry cycle
    t_ls_addr = 64'h8000_3000; t_we = 1'b0; t_op = 3'b000;
    do_txn(1'b0, 1'b1, 1'b0, 0, 7, 64'h0123_4567_89AB_CDEF, 1'b0);
    t_if_addr = 64'h8000_0024;
    do_txn(1'b1, 1'b0, 1'b0, 3, 4, 64'h0BAD_C0DE_7654_3210, 1'b0);

    // Timeout with no response: one error pulse with zero data
    t_ls_addr = 64'h8000_4000; t_we = 1'b0; t_op = 3'b011;
    if_valid = 1'b0; ls_valid = 1'b1; ls_addr = t_ls_addr; ls_we = t_we; ls_op = t_op;
    #1;
    chk("tmo_grant", ls_ready, 1'b1);
    mdl_last_ls = 1'b1;
    cyc();
    ls_valid = 1'b0;
    pulses = 0;
    for (int i = 0; i < 14; i++) begin
      mem_ready = (i == 0);
      #1;
      chk("tmo_mem_valid", mem_valid, i == 0);
      chk("tmo_rvalid_timing", ls_rvalid, i == int'(TMO) + 1);
      chk("tmo_no_if_rvalid", if_rvalid, 1'b0);
      if (ls_rvalid) begin
        pulses++;
        chk("tmo_err", ls_err, 1'b1);
        chk("tmo_rdata", ls_rdata, 64'd0);
      end
      cyc();
    end
    mem_ready = 1'b0;
    chk("tmo_pulse_count", pulses, 1);

    // Randomized traffic, all completing within the timeout
    for (int n = 0; n < 40; n++) begin
      int sel;
      sel       = int'($urandom_range(2, 0));
      t_if_addr = {$urandom, $urandom};
      t_ls_addr = {$urandom, $urandom};
      t_wdata   = {$urandom, $urandom};
      t_we      = 1'($urandom_range(1, 0));
      t_op      = 3'($urandom_range(7, 0));
      do_txn(sel != 1, sel != 0, 1'($urandom_range(1, 0)), int'($urandom_range(3, 0)),
             int'($urandom_range(4, 0)), {$urandom, $urandom}, 1'($urandom_range(1, 0)));
    end

    // Reset in the middle of a fetch wait, then a stray response
    t_if_addr = 64'h8000_0008;
    if_valid = 1'b1; if_addr = t_if_addr; ls_valid = 1'b0;
    #1;
    chk("mid_rst_grant", if_ready, 1'b1);
    cyc();
    if_valid = 1'b0; mem_ready = 1'b1;
    cyc();
    mem_ready = 1'b0;
    #1;
    chk("pre_rst_busy", outs_or, 1'b1);
    #1;
    rst = 1'b0; if_valid = 1'b1; ls_valid = 1'b1;
    #1;
    chk("mid_rst_outputs", outs_or, 1'b0);
    cyc();
    #2 rst = 1'b1; if_valid = 1'b0; ls_valid = 1'b0;
    cyc();
    mem_rvalid = 1'b1; mem_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
    cyc();
    mem_rvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("stray_rvalid_ignored", {if_rvalid, ls_rvalid}, 2'b00);
      cyc();
    end
    mdl_last_ls = 1'b0;
    t_if_addr = 64'h8000_0100; t_ls_addr = 64'h8000_0200; t_we = 1'b0; t_op = 3'b010;
    do_txn(1'b1, 1'b1, 1'b0, 0, 0, 64'h2468_ACE0_1357_9BDF, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/ysyx_220066_mem_arb.md
YSYX_220066_MEM_ARB -- requirements
Module: ysyx_220066_mem_arb

Interface
REQ-001 Parameter TIMEOUT, default 255, SHALL set the cycle limit for one transaction (REQ+WAIT) before an error is forced; 8-bit counter.
REQ-002 Clock and reset SHALL be: clk in 1, single clock, rising edge; rst in 1, asynchronous, active-low.
REQ-003 Fetch port SHALL be:
- if_valid in 1: fetch request
- if_addr in 64: fetch address
- if_ready out 1: request accepted
- if_rvalid out 1: fetch response pulse
- if_rdata out 32: instruction
- if_err out 1: fetch fault, valid with if_rvalid
REQ-004 Load/store port SHALL be:
- ls_valid in 1: request
- ls_we in 1: 1 = store
- ls_op in 3: MemOp width/sign code, passed through
- ls_addr in 64: address
- ls_wdata in 64: store data
- ls_ready out 1: request accepted
- ls_rvalid out 1: response pulse
- ls_rdata out 64: load data
- ls_err out 1: fault, valid with ls_rvalid
REQ-005 Memory port SHALL be:
- mem_valid out 1: request
- mem_ready in 1: request accepted
- mem_we out 1: write enable
- mem_op out 3: MemOp code
- mem_addr out 64: address
- mem_wdata out 64: write data
- mem_rvalid in 1: response
- mem_rdata in 64: read data
- mem_err in 1: bus error

Function
REQ-006 The FSM SHALL have exactly five states: IDLE, REQ_IF, REQ_LS, WAIT_IF, WAIT_LS.
REQ-007 In IDLE, grant SHALL be decided combinationally:
- sole requester wins
- if both request, the one not in the last_grant register wins
- ready to the winner SHALL be high in that same cycle
- ready to the loser SHALL be 0
REQ-008 On grant, address, we, op and wdata SHALL be latched; fetch forces we=0 and op=3'b011.
REQ-009 On grant, last_grant SHALL update to the winner and the FSM SHALL enter REQ_IF or REQ_LS.
REQ-010 In REQ_x, mem_valid SHALL be 1 with the latched fields stable until a cycle with mem_ready=1; the FSM then enters WAIT_x.
REQ-011 In WAIT_x, the cycle mem_rvalid=1 SHALL capture the response; x_rvalid SHALL pulse exactly one cycle later with registered data, and the FSM returns to IDLE.
REQ-012 Fetch data SHALL be mem_rdata[31:0] if latched addr[2]=0, else mem_rdata[63:32]; ls_rdata SHALL be mem_rdata unmodified.
REQ-013 x_err SHALL equal the mem_err captured with mem_rvalid.
REQ-014 New grants SHALL NOT occur in the cycle x_rvalid pulses, so minimum request-to-request spacing is 4 cycles.
REQ-015 The timeout counter SHALL clear on grant and increment each cycle in REQ_x/WAIT_x.
REQ-016 When the counter equals TIMEOUT without a response, the block SHALL pulse x_rvalid=1, x_err=1, x_rdata=0, and return to IDLE.
REQ-017 A response completing in the same cycle the counter reaches TIMEOUT SHALL be treated as a normal response.
REQ-018 mem_rvalid outside WAIT_x SHALL be ignored.
REQ-019 mem_ready outside REQ_x SHALL be ignored.
REQ-020 Requester valid dropping after grant SHALL NOT abort the transaction.
REQ-021 A request arriving while the FSM is not in IDLE SHALL be held off (ready=0) until IDLE.
REQ-022 At most one transaction SHALL be outstanding; no response SHALL be delivered to the non-granted port.

Reset
REQ-023 rst=0 SHALL asynchronously force:
- FSM=IDLE, last_grant=IF, counter=0
- all outputs 0: mem_valid, mem_we, mem_op, mem_addr, mem_wdata, x_ready, x_rvalid, x_err, x_rdata
REQ-024 Reset during REQ_x or WAIT_x SHALL drop the transaction silently; a late mem_rvalid after release SHALL be ignored.
REQ-025 With both ports requesting on the first IDLE cycle after reset, LS SHALL win (last_grant=IF).

Verification
REQ-026 Bench SHALL cover lone fetch: if_addr=0x80000004, mem_ready=1 immediately, mem_rvalid 2 cycles later with mem_rdata=0x11112222_33334444 -> if_rvalid one cycle later, if_rdata=0x11112222, if_err=0.
REQ-027 Bench SHALL cover simultaneous requests after reset -> ls_ready first.
- Next IDLE with both still requesting -> if_ready.
- Next -> ls_ready again (alternation).
REQ-028 Bench SHALL cover store with backpressure: ls_we=1, ls_addr=0x80001000, ls_wdata=0xDEADBEEF, ls_op=3'b011, mem_ready held 0 for 5 cycles -> mem_valid stays 1 with stable fields for those 5 cycles, then WAIT_LS.
REQ-029 Bench SHALL cover TIMEOUT=8 with no mem_rvalid -> ls_rvalid=1, ls_err=1, ls_rdata=0 exactly once, FSM back to IDLE.
REQ-030 Bench SHALL cover bus error: mem_rvalid=1 with mem_err=1 on a fetch -> if_rvalid=1, if_err=1.
REQ-031 Bench SHALL cover rst=0 mid WAIT_IF -> all outputs 0 immediately.
- After release, a stray mem_rvalid produces no if_rvalid.
